branch_predictor_btb: RTL and testbench

- Direct-mapped branch target buffer with 2-bit saturating direction counters for the 16-bit pipelined core.
- IF stage looks it up combinationally with the fetch PC and gets a predicted next PC.
- EX stage reports each resolved branch; the block updates its table and flags mispredicts so the core redirects and flushes.
- Replaces the always-not-taken fetch policy; all widths and depth are parametrised.

---
 rtl/branch_predictor_btb_pkg.sv | 20 ++
 rtl/branch_predictor_btb_sat_counter.sv | 22 ++
 rtl/branch_predictor_btb.sv | 123 ++++++++++++
 tb/tb_branch_predictor_btb.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/branch_predictor_btb_pkg.sv
// Shared definitions for the branch target buffer: counter encodings,
// the counter reset default and the entry-field widths.
package branch_predictor_btb_pkg;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  localparam logic [1:0] CTR_INIT_DEF = WNT;

  function automatic int tag_w(input int addr_w, input int idx_w);
    return addr_w - idx_w;
  endfunction

  function automatic int entry_w(input int addr_w, input int idx_w);
    return 1 + tag_w(addr_w, idx_w) + addr_w + 2;
  endfunction

endpackage

// File: rtl/branch_predictor_btb_sat_counter.sv
// 2-bit saturating direction counter next-state function for a table hit.
module bp_sat_counter
  import branch_predictor_btb_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       taken,
  input  logic       uncond,
  output logic [1:0] ctr_next
);

  always_comb begin
    ctr_next = ctr;
    if (uncond) begin
      ctr_next = ST;
    end else if (taken) begin
      if (ctr != ST) ctr_next = ctr + 2'b01;
    end else begin
      if (ctr != SNT) ctr_next = ctr - 2'b01;
    end
  end

endmodule

// File: rtl/branch_predictor_btb.sv
// Direct-mapped BTB with 2-bit direction counters: combinational IF lookup,
// EX-stage update and mispredict detection. BP_STATS_EN adds statistics counters.
module branch_predictor_btb
  import branch_predictor_btb_pkg::*;
#(
  parameter int         ADDR_W   = 16,
  parameter int         ENTRIES  = 16,
  parameter logic [1:0] CTR_INIT = CTR_INIT_DEF,
  parameter int         STAT_W   = 16
) (
  input  logic              clk,
  input  logic              pc_reset,
  input  logic [ADDR_W-1:0] if_pc,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  output logic [ADDR_W-1:0] pred_next_pc,
  input  logic              ex_update,
  input  logic              ex_uncond,
  input  logic [ADDR_W-1:0] ex_pc,
  input  logic              ex_taken,
  input  logic [ADDR_W-1:0] ex_target,
  input  logic              ex_pred_taken,
  input  logic [ADDR_W-1:0] ex_pred_target,
  output logic              ex_mispredict,
  output logic [ADDR_W-1:0] ex_redirect_pc,
  input  logic              bp_flush
`ifdef BP_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_branches,
  output logic [STAT_W-1:0] stat_mispredicts,
  output logic [STAT_W-1:0] stat_hits
`endif
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = tag_w(ADDR_W, IDX_W);

  if (ENTRIES < 2 || (ENTRIES & (ENTRIES - 1)) != 0 || STAT_W < 1) begin : g_param_check
    $error("branch_predictor_btb: ENTRIES must be a power of two >= 2 and STAT_W >= 1");
  end

  logic              valid_q  [ENTRIES];
  logic [TAG_W-1:0]  tag_q    [ENTRIES];
  logic [ADDR_W-1:0] target_q [ENTRIES];
  logic [1:0]        ctr_q    [ENTRIES];

  logic [IDX_W-1:0] if_idx, ex_idx;
  logic [TAG_W-1:0] if_tag, ex_tag;
  logic             lk_hit, ex_hit, mp_raw;
  logic [1:0]       ctr_upd, ctr_alloc;

  assign if_idx = if_pc[IDX_W-1:0];
  assign if_tag = if_pc[ADDR_W-1:IDX_W];
  assign ex_idx = ex_pc[IDX_W-1:0];
  assign ex_tag = ex_pc[ADDR_W-1:IDX_W];

  // Lookup reads the registered table only, so a same-cycle update is not bypassed.
  assign lk_hit       = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign pred_taken   = !pc_reset && lk_hit && ctr_q[if_idx][1];
  assign pred_target  = (!pc_reset && lk_hit) ? target_q[if_idx] : '0;
  assign pred_next_pc = pred_taken ? pred_target : if_pc + ADDR_W'(1);

  assign mp_raw = ex_update && ((ex_taken != ex_pred_taken) ||
                  (ex_taken && ex_pred_taken && (ex_target != ex_pred_target)));
  assign ex_mispredict  = mp_raw && !pc_reset;
  assign ex_redirect_pc = ex_taken ? ex_target : ex_pc + ADDR_W'(1);

  assign ex_hit    = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
  assign ctr_alloc = ex_uncond ? ST : WT;

  bp_sat_counter u_sat_counter (
    .ctr      (ctr_q[ex_idx]),
    .taken    (ex_taken),
    .uncond   (ex_uncond),
    .ctr_next (ctr_upd)
  );

  always_ff @(posedge clk) begin
    if (pc_reset || bp_flush) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= CTR_INIT;
      end
    end else if (ex_update) begin
      if (ex_hit) begin
        ctr_q[ex_idx] <= ctr_upd;
      end else if (ex_taken) begin
        valid_q[ex_idx] <= 1'b1;
        ctr_q[ex_idx]   <= ctr_alloc;
      end
    end
  end

  // Tags and targets carry no reset; valid gates their use.
  always_ff @(posedge clk) begin
    if (!pc_reset && !bp_flush && ex_update) begin
      if (ex_hit) begin
        if (ex_taken || ex_uncond) target_q[ex_idx] <= ex_target;
      end else if (ex_taken) begin
        tag_q[ex_idx]    <= ex_tag;
        target_q[ex_idx] <= ex_target;
      end
    end
  end

`ifdef BP_STATS_EN
  always_ff @(posedge clk) begin
    if (pc_reset) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
      stat_hits        <= '0;
    end else begin
      if (ex_update && stat_branches != '1)
        stat_branches <= stat_branches + STAT_W'(1);
      if (ex_mispredict && stat_mispredicts != '1)
        stat_mispredicts <= stat_mispredicts + STAT_W'(1);
      if (lk_hit && stat_hits != '1)
        stat_hits <= stat_hits + STAT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Directed bench for branch_predictor_btb: vector table plus reset/flush sequences.
module tb_branch_predictor_btb;

  logic        clk = 1'b0;
  logic        pc_reset;
  logic [15:0] if_pc;
  logic        pred_taken;
  logic [15:0] pred_target, pred_next_pc;
  logic        ex_update, ex_uncond, ex_taken, ex_pred_taken;
  logic [15:0] ex_pc, ex_target, ex_pred_target;
  logic        ex_mispredict;
  logic [15:0] ex_redirect_pc;
  logic        bp_flush;
`ifdef BP_STATS_EN
  logic [15:0] stat_branches, stat_mispredicts, stat_hits;
  int          exp_branches = 0;
  int          exp_mispredicts = 0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  branch_predictor_btb dut (
    .clk            (clk),
    .pc_reset       (pc_reset),
    .if_pc          (if_pc),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .pred_next_pc   (pred_next_pc),
    .ex_update      (ex_update),
    .ex_uncond      (ex_uncond),
    .ex_pc          (ex_pc),
    .ex_taken       (ex_taken),
    .ex_target      (ex_target),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pred_target (ex_pred_target),
    .ex_mispredict  (ex_mispredict),
    .ex_redirect_pc (ex_redirect_pc),
    .bp_flush       (bp_flush)
`ifdef BP_STATS_EN
    ,
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts),
    .stat_hits        (stat_hits)
`endif
  );

  typedef struct {
    logic [15:0] if_pc;
    logic        upd;
    logic        unc;
    logic [15:0] ex_pc;
    logic        tk;
    logic [15:0] tgt;
    logic        ptk;
    logic [15:0] ptgt;
    logic        exp_pt;
    logic [15:0] exp_npc;
    logic        exp_mp;
    logic [15:0] exp_rd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [15:0] ipc, input logic upd, input logic unc,
                              input logic [15:0] epc, input logic tk, input logic [15:0] tgt,
                              input logic ptk, input logic [15:0] ptgt, input logic ept,
                              input logic [15:0] enpc, input logic emp, input logic [15:0] erd);
    vec_t v;
    v.if_pc = ipc; v.upd = upd; v.unc = unc; v.ex_pc = epc; v.tk = tk; v.tgt = tgt;
    v.ptk = ptk; v.ptgt = ptgt; v.exp_pt = ept; v.exp_npc = enpc; v.exp_mp = emp; v.exp_rd = erd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", nm, act, exp);
    end
  endtask

  task automatic drive_ex(input logic upd, input logic unc, input logic [15:0] epc,
                          input logic tk, input logic [15:0] tgt, input logic ptk,
                          input logic [15:0] ptgt);
    ex_update = upd; ex_uncond = unc; ex_pc = epc; ex_taken = tk;
    ex_target = tgt; ex_pred_taken = ptk; ex_pred_target = ptgt;
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    string s;
    @(negedge clk);
    if_pc = v.if_pc;
    drive_ex(v.upd, v.unc, v.ex_pc, v.tk, v.tgt, v.ptk, v.ptgt);
    #1;
    s = $sformatf("v%0d", idx);
    chk({s, ".pred_taken"}, {15'd0, pred_taken}, {15'd0, v.exp_pt});
    chk({s, ".pred_next_pc"}, pred_next_pc, v.exp_npc);
    chk({s, ".ex_mispredict"}, {15'd0, ex_mispredict}, {15'd0, v.exp_mp});
    if (v.exp_mp) chk({s, ".ex_redirect_pc"}, ex_redirect_pc, v.exp_rd);
    if (v.exp_pt) chk({s, ".pred_target"}, pred_target, v.exp_npc);
`ifdef BP_STATS_EN
    if (v.upd) exp_branches++;
    if (v.exp_mp) exp_mispredicts++;
`endif
  endtask

  task automatic lookup_chk(input string nm, input logic [15:0] pc, input logic ept,
                            input logic [15:0] enpc, input logic [15:0] etgt);
    if_pc = pc;
    #1;
    chk({nm, ".pred_taken"}, {15'd0, pred_taken}, {15'd0, ept});
    chk({nm, ".pred_next_pc"}, pred_next_pc, enpc);
    chk({nm, ".pred_target"}, pred_target, etgt);
  endtask

  initial begin
    pc_reset = 1'b1;
    bp_flush = 1'b0;
    if_pc    = 16'h0000;
    drive_ex(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0);
    repeat (3) @(posedge clk);

    // Outputs held quiet while reset is asserted, even with a mismatching update.
    @(negedge clk);
    drive_ex(1'b1, 1'b0, 16'h0013, 1'b1, 16'h0040, 1'b0, 16'h0);
    lookup_chk("in_reset", 16'h0013, 1'b0, 16'h0014, 16'h0000);
    chk("in_reset.ex_mispredict", {15'd0, ex_mispredict}, 16'h0);

    @(negedge clk);
    pc_reset = 1'b0;
    drive_ex(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0);
`ifdef BP_STATS_EN
    #1;
    chk("stats0.branches", stat_branches, 16'd0);
    chk("stats0.mispredicts", stat_mispredicts, 16'd0);
    chk("stats0.hits", stat_hits, 16'd0);
`endif

    //            if_pc    upd unc ex_pc    tk  tgt      ptk ptgt     pt  npc      mp  redirect
    vecs.push_back(mk(16'h0013, 1, 0, 16'h0013, 0, 16'h0000, 0, 16'h0000, 0, 16'h0014, 0, 16'h0000));
    vecs.push_back(mk(16'h0013, 1, 0, 16'h0013, 1, 16'h0040, 0, 16'h0000, 0, 16'h0014, 1, 16'h0040));
    vecs.push_back(mk(16'h0013, 1, 0, 16'h0013, 0, 16'h0000, 1, 16'h0040, 1, 16'h0040, 1, 16'h0014));
    vecs.push_back(mk(16'h0013, 1, 0, 16'h0013, 1, 16'h0040, 0, 16'h0000, 0, 16'h0014, 1, 16'h0040));
    vecs.push_back(mk(16'h0013, 1, 0, 16'h0013, 1, 16'h0040, 1, 16'h0040, 1, 16'h0040, 0, 16'h0000));
    vecs.push_back(mk(16'h0013, 1, 0, 16'h0013, 0, 16'h0000, 1, 16'h0040, 1, 16'h0040, 1, 16'h0014));
    vecs.push_back(mk(16'h0013, 1, 0, 16'h0013, 1, 16'h0040, 1, 16'h0040, 1, 16'h0040, 0, 16'h0000));
    vecs.push_back(mk(16'h0013, 1, 1, 16'h0013, 1, 16'h0050, 1, 16'h0040, 1, 16'h0040, 1, 16'h0050));
    vecs.push_back(mk(16'h0013, 0, 0, 16'h0013, 1, 16'h0060, 0, 16'h0000, 1, 16'h0050, 0, 16'h0000));
    vecs.push_back(mk(16'h0023, 1, 0, 16'h0023, 1, 16'h0080, 0, 16'h0000, 0, 16'h0024, 1, 16'h0080));
    vecs.push_back(mk(16'h0013, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0014, 0, 16'h0000));
    vecs.push_back(mk(16'h0023, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 1, 16'h0080, 0, 16'h0000));
    vecs.push_back(mk(16'hFFFF, 1, 0, 16'hFFFF, 0, 16'h0000, 1, 16'h0010, 0, 16'h0000, 1, 16'h0000));
    vecs.push_back(mk(16'h0023, 1, 0, 16'h0023, 0, 16'h0000, 1, 16'h0080, 1, 16'h0080, 1, 16'h0024));
    vecs.push_back(mk(16'h0023, 1, 0, 16'h0023, 0, 16'h0000, 0, 16'h0000, 0, 16'h0024, 0, 16'h0000));
    vecs.push_back(mk(16'h0023, 1, 0, 16'h0023, 0, 16'h0000, 0, 16'h0000, 0, 16'h0024, 0, 16'h0000));
    vecs.push_back(mk(16'h0023, 1, 0, 16'h0023, 1, 16'h0080, 0, 16'h0000, 0, 16'h0024, 1, 16'h0080));
    vecs.push_back(mk(16'h0023, 1, 0, 16'h0023, 1, 16'h0080, 0, 16'h0000, 0, 16'h0024, 1, 16'h0080));
    vecs.push_back(mk(16'h0023, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 1, 16'h0080, 0, 16'h0000));
    vecs.push_back(mk(16'h0005, 1, 1, 16'h0005, 1, 16'h0100, 0, 16'h0000, 0, 16'h0006, 1, 16'h0100));
    vecs.push_back(mk(16'h0005, 1, 0, 16'h0005, 0, 16'h0000, 1, 16'h0100, 1, 16'h0100, 1, 16'h0006));
    vecs.push_back(mk(16'h0005, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 1, 16'h0100, 0, 16'h0000));

    foreach (vecs[i]) apply_vec(vecs[i], i);

`ifdef BP_STATS_EN
    @(negedge clk);
    drive_ex(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0);
    #1;
    chk("stats1.branches", stat_branches, 16'(exp_branches));
    chk("stats1.mispredicts", stat_mispredicts, 16'(exp_mispredicts));
`endif

    // Flush together with a taken miss: table cleared, allocation dropped.
    @(negedge clk);
    bp_flush = 1'b1;
    drive_ex(1'b1, 1'b0, 16'h0007, 1'b1, 16'h0070, 1'b0, 16'h0000);
    lookup_chk("pre_flush", 16'h0023, 1'b1, 16'h0080, 16'h0080);
    chk("flush.ex_mispredict", {15'd0, ex_mispredict}, 16'h0001);
    chk("flush.ex_redirect_pc", ex_redirect_pc, 16'h0070);
`ifdef BP_STATS_EN
    exp_branches++;
    exp_mispredicts++;
`endif
    @(negedge clk);
    bp_flush = 1'b0;
    drive_ex(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0);
    lookup_chk("post_flush_23", 16'h0023, 1'b0, 16'h0024, 16'h0000);
    lookup_chk("post_flush_05", 16'h0005, 1'b0, 16'h0006, 16'h0000);
    lookup_chk("post_flush_07", 16'h0007, 1'b0, 16'h0008, 16'h0000);
`ifdef BP_STATS_EN
    chk("stats_flush.branches", stat_branches, 16'(exp_branches));
    chk("stats_flush.mispredicts", stat_mispredicts, 16'(exp_mispredicts));
`endif

    // Reset mid-operation: live entry masked during reset and gone afterwards.
    @(negedge clk);
    drive_ex(1'b1, 1'b0, 16'h0013, 1'b1, 16'h0040, 1'b0, 16'h0000);
    @(negedge clk);
    drive_ex(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0);
    lookup_chk("pre_reset_13", 16'h0013, 1'b1, 16'h0040, 16'h0040);
    @(negedge clk);
    pc_reset = 1'b1;
    drive_ex(1'b1, 1'b0, 16'h0007, 1'b1, 16'h0070, 1'b0, 16'h0000);
    lookup_chk("mid_reset_13", 16'h0013, 1'b0, 16'h0014, 16'h0000);
    chk("mid_reset.ex_mispredict", {15'd0, ex_mispredict}, 16'h0000);
    @(negedge clk);
    pc_reset = 1'b0;
    drive_ex(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0);
    lookup_chk("post_reset_13", 16'h0013, 1'b0, 16'h0014, 16'h0000);
    lookup_chk("post_reset_07", 16'h0007, 1'b0, 16'h0008, 16'h0000);
`ifdef BP_STATS_EN
    chk("stats_reset.branches", stat_branches, 16'd0);
    chk("stats_reset.mispredicts", stat_mispredicts, 16'd0);
    chk("stats_reset.hits", stat_hits, 16'd0);
`endif

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
